bcd_subtractor_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_sub.sv | 21 ++
 rtl/bcd_subtractor_seq.sv | 141 ++++++++++++++
 tb/tb_bcd_subtractor_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and state encoding for the BCD subtractor slice.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam bcd_digit_t BCD_RADIX = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        NEG,
        DONE
    } sub_state_t;

    // A digit is illegal when it is above 9 (bit3 & (bit2 | bit1)).
    function automatic logic is_illegal_digit(input bcd_digit_t d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract: d = a - b - bin, with borrow out.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    logic [4:0] t;

    // 5-bit difference; a negative result is corrected by adding the radix.
    always_comb begin
        t    = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
        bout = t[4];
        d    = t[4] ? (t[3:0] + BCD_RADIX) : t[3:0];
    end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// Sequential multi-digit BCD subtractor, one digit per clock, LSD first.
// Optional macro BCD_SUB_SIGN_MAG_EN: converts a negative ten's-complement
// result into sign/magnitude with an extra NDIGITS-cycle pass.
module bcd_subtractor_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] A,
    input  logic [4*NDIGITS-1:0] B,
    input  logic                 b_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIGITS-1:0] diff,
    output logic                 b_out,
    output logic                 negative,
    output logic                 out_of_range
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    sub_state_t    state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic          illegal;
    bcd_digit_t    op_a;
    bcd_digit_t    op_b;
    bcd_digit_t    d;
    logic          bout;

    // Flag any non-BCD digit in either operand at the capture point.
    always_comb begin
        illegal = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (is_illegal_digit(A[4*i +: 4]) || is_illegal_digit(B[4*i +: 4]))
                illegal = 1'b1;
        end
    end

    // Operand mux feeding the shared digit subtractor.
    always_comb begin
        op_a = a_sr[3:0];
        op_b = b_sr[3:0];
`ifdef BCD_SUB_SIGN_MAG_EN
        if (state == NEG) begin
            op_a = '0;
            op_b = diff[3:0];
        end
`endif
    end

    bcd_digit_sub u_digit (
        .a    (op_a),
        .b    (op_b),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // Control FSM with registered outputs; result digits enter diff at the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            borrow       <= 1'b0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            diff         <= '0;
            b_out        <= 1'b0;
            negative     <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr         <= A;
                        b_sr         <= B;
                        borrow       <= b_in;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        diff         <= '0;
                        b_out        <= 1'b0;
                        negative     <= 1'b0;
                        out_of_range <= illegal;
                        state        <= illegal ? DONE : SUB;
                    end
                end
                SUB: begin
                    diff   <= (diff >> 4) | (W'(d) << (W - 4));
                    a_sr   <= a_sr >> 4;
                    b_sr   <= b_sr >> 4;
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        b_out    <= bout;
                        negative <= bout;
`ifdef BCD_SUB_SIGN_MAG_EN
                        if (bout) begin
                            borrow <= 1'b0;
                            state  <= NEG;
                        end else begin
                            state  <= DONE;
                        end
`else
                        state    <= DONE;
`endif
                    end
                end
`ifdef BCD_SUB_SIGN_MAG_EN
                NEG: begin
                    diff   <= (diff >> 4) | (W'(d) << (W - 4));
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq (NDIGITS = 4).
module tb_bcd_subtractor_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         negative;
    logic         out_of_range;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bo;
        logic         neg;
        logic         oor;
        int           lat;
    } vec_t;

    typedef struct {
        vec_t  v;
        int    ks;
        string tag;
    } exp_t;

    exp_t q[$];
    vec_t vecs[10];

    bcd_subtractor_seq #(.NDIGITS(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .A            (A),
        .B            (B),
        .b_in         (b_in),
        .busy         (busy),
        .done         (done),
        .diff         (diff),
        .b_out        (b_out),
        .negative     (negative),
        .out_of_range (out_of_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model working on decimal integers.
    function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic bin);
        vec_t v;
        int ai = 0, bi = 0, p = 1, r, dv;
        bit bad = 0;
        for (int i = 0; i < N; i++) begin
            int da, db;
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) bad = 1;
            ai += da * p;
            bi += db * p;
            p  *= 10;
        end
        v.a = a; v.b = b; v.bin = bin;
        if (bad) begin
            v.diff = '0; v.bo = 0; v.neg = 0; v.oor = 1; v.lat = 1;
            return v;
        end
        r = ai - bi - int'(bin);
        v.oor = 0;
        v.neg = (r < 0);
        v.bo  = (r < 0);
        v.lat = N + 1;
`ifdef BCD_SUB_SIGN_MAG_EN
        dv = (r < 0) ? ((-r) % p) : r;
        if (r < 0) v.lat = 2 * N + 1;
`else
        dv = (r < 0) ? (r + p) : r;
`endif
        v.diff = '0;
        for (int i = 0; i < N; i++) begin
            v.diff[4*i +: 4] = 4'(dv % 10);
            dv = dv / 10;
        end
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(vec_t v, string tag);
        exp_t e;
        e.v   = v;
        e.ks  = cyc + 1;
        e.tag = tag;
        q.push_back(e);
    endtask

    // Pulse start for one cycle, record the expectation, check busy.
    task automatic launch(vec_t v, string tag);
        @(negedge clk);
        A = v.a; B = v.b; b_in = v.bin; start = 1'b1;
        push_exp(v, tag);
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s busy", tag), 32'(busy), 32'(1));
    endtask

    // Wait (bounded) for done and compare against the scoreboard head.
    task automatic wait_done(int bound);
        bit   got = 0;
        exp_t e;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk($sformatf("%s diff", e.tag), 32'(diff), 32'(e.v.diff));
                    chk($sformatf("%s b_out", e.tag), 32'(b_out), 32'(e.v.bo));
                    chk($sformatf("%s negative", e.tag), 32'(negative), 32'(e.v.neg));
                    chk($sformatf("%s out_of_range", e.tag), 32'(out_of_range), 32'(e.v.oor));
                    chk($sformatf("%s latency", e.tag), 32'(cyc - e.ks), 32'(e.v.lat));
                end
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done");
            q.delete();
        end
    endtask

    task automatic count_done(int ncyc, output int seen);
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    initial begin
        int   seen;
        vec_t v;

        vecs[0] = mk(16'h5432, 16'h1234, 1'b0);
        vecs[1] = mk(16'h0100, 16'h0001, 1'b0);
        vecs[2] = mk(16'h0000, 16'h0001, 1'b0);
        vecs[3] = mk(16'h1000, 16'h0999, 1'b1);
        vecs[4] = mk(16'h12A4, 16'h0001, 1'b0);
        vecs[5] = mk(16'h9999, 16'h0000, 1'b1);
        vecs[6] = mk(16'h0000, 16'h9999, 1'b1);
        vecs[7] = mk(16'h1234, 16'h5678, 1'b0);
        vecs[8] = mk(16'h0009, 16'h000F, 1'b0);
        vecs[9] = mk(16'h8000, 16'h0001, 1'b0);

        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; b_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({busy, done, b_out, negative, out_of_range, diff}), 32'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i], $sformatf("vec%0d", i));
            wait_done(40);
        end

        // Start pulsed again during SUB must not disturb the running operation.
        launch(vecs[0], "busy_start");
        @(negedge clk);
        A = 16'h0000; B = 16'h0001; b_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        count_done(12, seen);
        chk("busy_start extra done", 32'(seen), 32'(0));

        // Start held high: a second operation is accepted right after DONE.
        @(negedge clk);
        A = vecs[7].a; B = vecs[7].b; b_in = vecs[7].bin; start = 1'b1;
        push_exp(vecs[7], "hold1");
        wait_done(40);
        A = vecs[1].a; B = vecs[1].b; b_in = vecs[1].bin;
        push_exp(vecs[1], "hold2");
        @(negedge clk);
        start = 1'b0;
        chk("hold done one cycle", 32'(done), 32'(0));
        chk("hold busy again", 32'(busy), 32'(1));
        wait_done(40);

        // Reset asserted mid-operation aborts with no done pulse.
        @(negedge clk);
        A = vecs[0].a; B = vecs[0].b; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort outputs", 32'({busy, done, b_out, negative, out_of_range, diff}), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        count_done(12, seen);
        chk("abort no done", 32'(seen), 32'(0));

        v = mk(16'h2001, 16'h0002, 1'b0);
        launch(v, "post_abort");
        wait_done(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
